// File: rtl/fpu_add_arbiter.sv
`timescale 1ns/1ps
// fpu_add_arbiter: round-robin sharing of one floating-point adder between requesters A and B.
// Define FPU_ARB_GRANT_CNT_EN to add 16-bit per-requester acceptance counters (a/b_grant_cnt).
module fpu_add_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_stb,
    input  logic [WIDTH-1:0] a_in_a,
    input  logic [WIDTH-1:0] a_in_b,
    input  logic             b_stb,
    input  logic [WIDTH-1:0] b_in_a,
    input  logic [WIDTH-1:0] b_in_b,
    output logic             a_busy,
    output logic             b_busy,
    output logic [WIDTH-1:0] a_res,
    output logic [WIDTH-1:0] b_res,
    output logic             a_res_stb,
    output logic             b_res_stb,
    input  logic             a_res_busy,
    input  logic             b_res_busy,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    output logic             add_stb,
    input  logic             add_busy,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_out_stb,
    output logic             add_out_busy
`ifdef FPU_ARB_GRANT_CNT_EN
    ,
    output logic [15:0]      a_grant_cnt,
    output logic [15:0]      b_grant_cnt
`endif
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ISSUE       = 2'd1;
    localparam logic [1:0] WAIT_RESULT = 2'd2;
    localparam logic [1:0] DELIVER     = 2'd3;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             add_stb_q, add_stb_d;
    logic             add_out_busy_q, add_out_busy_d;
    logic             a_res_stb_q, a_res_stb_d;
    logic             b_res_stb_q, b_res_stb_d;

    logic grant_a, grant_b, accept, owner_res_busy;

    // B wins a tie only when A was served last; a lone requester always wins.
    assign grant_b        = b_stb && (!a_stb || (last_owner_q == OWNER_A));
    assign grant_a        = a_stb && !grant_b;
    assign accept         = (state_q == IDLE) && (grant_a || grant_b);
    assign owner_res_busy = (owner_q == OWNER_B) ? b_res_busy : a_res_busy;

    assign a_busy       = rst || (state_q != IDLE) || !grant_a;
    assign b_busy       = rst || (state_q != IDLE) || !grant_b;
    assign add_in_a     = op_a_q;
    assign add_in_b     = op_b_q;
    assign add_stb      = add_stb_q;
    assign add_out_busy = add_out_busy_q;
    assign a_res        = sum_q;
    assign b_res        = sum_q;
    assign a_res_stb    = a_res_stb_q;
    assign b_res_stb    = b_res_stb_q;

    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        owner_d        = owner_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        sum_d          = sum_q;
        add_stb_d      = add_stb_q;
        add_out_busy_d = add_out_busy_q;
        a_res_stb_d    = a_res_stb_q;
        b_res_stb_d    = b_res_stb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d   = grant_b ? OWNER_B : OWNER_A;
                    op_a_d    = grant_b ? b_in_a : a_in_a;
                    op_b_d    = grant_b ? b_in_b : a_in_b;
                    add_stb_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!add_busy) begin
                    add_stb_d      = 1'b0;
                    add_out_busy_d = 1'b0;
                    state_d        = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (add_out_stb) begin
                    sum_d          = add_sum;
                    add_out_busy_d = 1'b1;
                    a_res_stb_d    = (owner_q == OWNER_A);
                    b_res_stb_d    = (owner_q == OWNER_B);
                    state_d        = DELIVER;
                end
            end
            DELIVER: begin
                if (!owner_res_busy) begin
                    a_res_stb_d  = 1'b0;
                    b_res_stb_d  = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset discards any in-flight operation and hands the first grant to A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_owner_q   <= OWNER_B;
            owner_q        <= OWNER_A;
            op_a_q         <= '0;
            op_b_q         <= '0;
            sum_q          <= '0;
            add_stb_q      <= 1'b0;
            add_out_busy_q <= 1'b1;
            a_res_stb_q    <= 1'b0;
            b_res_stb_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            owner_q        <= owner_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            sum_q          <= sum_d;
            add_stb_q      <= add_stb_d;
            add_out_busy_q <= add_out_busy_d;
            a_res_stb_q    <= a_res_stb_d;
            b_res_stb_q    <= b_res_stb_d;
        end
    end

`ifdef FPU_ARB_GRANT_CNT_EN
    logic [15:0] a_cnt_q, b_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q <= 16'd0;
            b_cnt_q <= 16'd0;
        end else if (accept) begin
            if (grant_b) b_cnt_q <= b_cnt_q + 16'd1;
            else         a_cnt_q <= a_cnt_q + 16'd1;
        end
    end

    assign a_grant_cnt = a_cnt_q;
    assign b_grant_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_add_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for fpu_add_arbiter: behavioural requesters, a stand-in adder with
// programmable latency and a per-requester scoreboard of expected results.
module tb_fpu_add_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_stb = 1'b0, b_stb = 1'b0;
    logic [W-1:0] a_in_a = '0, a_in_b = '0, b_in_a = '0, b_in_b = '0;
    logic         a_busy, b_busy, a_res_stb, b_res_stb;
    logic [W-1:0] a_res, b_res, add_in_a, add_in_b;
    logic         a_res_busy = 1'b0, b_res_busy = 1'b0;
    logic         add_stb, add_out_busy;
    logic         add_busy = 1'b0, add_out_stb = 1'b0;
    logic [W-1:0] add_sum = '0;
`ifdef FPU_ARB_GRANT_CNT_EN
    logic [15:0]  a_grant_cnt, b_grant_cnt;
`endif

    fpu_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .a_stb(a_stb), .a_in_a(a_in_a), .a_in_b(a_in_b),
        .b_stb(b_stb), .b_in_a(b_in_a), .b_in_b(b_in_b),
        .a_busy(a_busy), .b_busy(b_busy),
        .a_res(a_res), .b_res(b_res),
        .a_res_stb(a_res_stb), .b_res_stb(b_res_stb),
        .a_res_busy(a_res_busy), .b_res_busy(b_res_busy),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_stb(add_stb), .add_busy(add_busy),
        .add_sum(add_sum), .add_out_stb(add_out_stb), .add_out_busy(add_out_busy)
`ifdef FPU_ARB_GRANT_CNT_EN
        , .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] opA; logic [W-1:0] opB; logic [W-1:0] sum; } op_t;
    typedef struct { logic [W-1:0] opA; logic [W-1:0] opB; logic [W-1:0] sum; int acceptCyc; int expLat; } exp_t;
    typedef struct { bit useB; logic [W-1:0] opA; logic [W-1:0] opB; int lat; logic [W-1:0] expSum; } vec_t;

    op_t  pendA[$], pendB[$];
    exp_t expA[$], expB[$];
    bit   orderLog[$];
    exp_t inflight;
    vec_t vecs[6];

    int checks = 0, failures = 0, cyc = 0;
    int adderLat = 1, extraLatA = 0, extraLatB = 0;
    int addBusyHold = 0, aResHold = 0, bResHold = 0;
    int cnt = 0, addXferCount = 0, resultsDone = 0;
    int clearReq = 0, clearAck = 0;
    bit outXfer = 0, accA = 0, accB = 0;
    bit prevAddHeld = 0, prevAHeld = 0, prevBHeld = 0;
    logic [W-1:0] pendingSum = '0, prevAddA = '0, prevAddB = '0, prevARes = '0, prevBRes = '0;

    // Stand-in adder: the arbiter never does arithmetic, so any non-commutative function
    // exposes swapped or corrupted operands; the 1.0 + 2.0 case returns the real sum.
    function automatic logic [W-1:0] fakeAdd(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
        return x ^ {y[W-2:0], y[W-1]};
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input bit useB, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] s);
        op_t o;
        o.opA = x; o.opB = y; o.sum = s;
        if (useB) pendB.push_back(o);
        else      pendA.push_back(o);
    endtask

    task automatic waitResults(input int target, input int budget);
        int k = 0;
        while (resultsDone < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (resultsDone < target) begin
            checks++;
            failures++;
            $display("[TB] FAIL waitResults actual=%0d required=%0d", resultsDone, target);
        end
    endtask

    always @(posedge clk) cyc++;

    // Everything that talks to the DUT runs here: effects of the last posedge first, then
    // new input values, then (after settling) the handshakes the next posedge will complete.
    always @(negedge clk) begin
        exp_t e;
        if (clearReq != clearAck) begin
            clearAck = clearReq; add_out_stb = 1'b0; cnt = 0; outXfer = 0;
        end
        if (accA) begin void'(pendA.pop_front()); accA = 0; end
        if (accB) begin void'(pendB.pop_front()); accB = 0; end
        if (outXfer) begin add_out_stb = 1'b0; outXfer = 0; end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin add_out_stb = 1'b1; add_sum = pendingSum; end
        end

        a_stb = (pendA.size() > 0);
        if (a_stb) begin a_in_a = pendA[0].opA; a_in_b = pendA[0].opB; end
        b_stb = (pendB.size() > 0);
        if (b_stb) begin b_in_a = pendB[0].opA; b_in_b = pendB[0].opB; end
        add_busy = 1'b0;
        if (add_stb && addBusyHold > 0) begin add_busy = 1'b1; addBusyHold--; end
        a_res_busy = 1'b0;
        if (a_res_stb && aResHold > 0) begin a_res_busy = 1'b1; aResHold--; end
        b_res_busy = 1'b0;
        if (b_res_stb && bResHold > 0) begin b_res_busy = 1'b1; bResHold--; end

        #1;
        if (!rst) begin
            if (prevAddHeld) begin
                checkOutput("addStbHeld", add_stb, 1);
                checkOutput("addInAStable", add_in_a, prevAddA);
                checkOutput("addInBStable", add_in_b, prevAddB);
            end
            prevAddHeld = add_stb && add_busy; prevAddA = add_in_a; prevAddB = add_in_b;
            if (prevAHeld) begin
                checkOutput("aResStbHeld", a_res_stb, 1);
                checkOutput("aResStable", a_res, prevARes);
            end
            if (prevBHeld) begin
                checkOutput("bResStbHeld", b_res_stb, 1);
                checkOutput("bResStable", b_res, prevBRes);
            end
            prevAHeld = a_res_stb && a_res_busy; prevARes = a_res;
            prevBHeld = b_res_stb && b_res_busy; prevBRes = b_res;
            if (a_res_stb || b_res_stb) begin
                checkOutput("busyInDeliver", {a_busy, b_busy}, 2'b11);
                checkOutput("oneResStb", a_res_stb & b_res_stb, 0);
            end

            accA = a_stb && !a_busy;
            accB = b_stb && !b_busy;
            if (accA || accB) begin
                checkOutput("singleGrant", accA & accB, 0);
                e.opA = accB ? b_in_a : a_in_a;
                e.opB = accB ? b_in_b : a_in_b;
                e.sum = accB ? pendB[0].sum : pendA[0].sum;
                e.acceptCyc = cyc + 1;
                e.expLat = adderLat + 3 + (accB ? extraLatB : extraLatA);
                inflight = e;
                if (accB) expB.push_back(e);
                else      expA.push_back(e);
                orderLog.push_back(accB);
            end

            if (add_stb && !add_busy) begin
                checkOutput("oneAdderOp", (cnt == 0) && !add_out_stb, 1);
                checkOutput("addInA", add_in_a, inflight.opA);
                checkOutput("addInB", add_in_b, inflight.opB);
                cnt = adderLat + 1;
                pendingSum = fakeAdd(add_in_a, add_in_b);
                addXferCount++;
            end
            if (add_out_stb && !add_out_busy) outXfer = 1;

            if (a_res_stb) begin
                checkOutput("aResExpected", expA.size() != 0, 1);
                if (!a_res_busy && expA.size() != 0) begin
                    e = expA.pop_front();
                    checkOutput("aRes", a_res, e.sum);
                    checkOutput("aLatency", cyc + 1 - e.acceptCyc, e.expLat);
                    resultsDone++;
                end
            end
            if (b_res_stb) begin
                checkOutput("bResExpected", expB.size() != 0, 1);
                if (!b_res_busy && expB.size() != 0) begin
                    e = expB.pop_front();
                    checkOutput("bRes", b_res, e.sum);
                    checkOutput("bLatency", cyc + 1 - e.acceptCyc, e.expLat);
                    resultsDone++;
                end
            end
        end else begin
            accA = 0; accB = 0; prevAddHeld = 0; prevAHeld = 0; prevBHeld = 0;
        end
    end

    initial begin
        int k;
        int pre;
        bit expOrder[5];
        vecs[0] = '{useB: 1'b0, opA: 32'h3F800000, opB: 32'h40000000, lat: 4, expSum: 32'h40400000};
        vecs[1] = '{useB: 1'b1, opA: 32'h00000000, opB: 32'h80000000, lat: 1, expSum: 32'h00000001};
        vecs[2] = '{useB: 1'b0, opA: 32'hFFFFFFFF, opB: 32'h00000000, lat: 0, expSum: 32'hFFFFFFFF};
        vecs[3] = '{useB: 1'b1, opA: 32'h12345678, opB: 32'h00000001, lat: 2, expSum: 32'h1234567A};
        vecs[4] = '{useB: 1'b0, opA: 32'h80000000, opB: 32'h00000001, lat: 3, expSum: 32'h80000002};
        vecs[5] = '{useB: 1'b1, opA: 32'h0000FFFF, opB: 32'h00008000, lat: 6, expSum: 32'h0001FFFF};
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // A request waits under reset; busy must stay high until reset releases.
        rst = 1'b1;
        adderLat = 1;
        applyStimulus(0, 32'h11111111, 32'h22222222, fakeAdd(32'h11111111, 32'h22222222));
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rstABusy", a_busy, 1);
        checkOutput("rstBBusy", b_busy, 1);
        checkOutput("rstAddStb", add_stb, 0);
        checkOutput("rstAddOutBusy", add_out_busy, 1);
        checkOutput("rstResStb", {a_res_stb, b_res_stb}, 0);
        checkOutput("rstARes", a_res, 0);
        checkOutput("rstAddInA", add_in_a, 0);
`ifdef FPU_ARB_GRANT_CNT_EN
        checkOutput("rstAGrantCnt", a_grant_cnt, 0);
`endif
        rst = 1'b0;
        waitResults(1, 300);

        for (int i = 0; i < 6; i++) begin
            adderLat = vecs[i].lat;
            applyStimulus(vecs[i].useB, vecs[i].opA, vecs[i].opB, vecs[i].expSum);
            waitResults(resultsDone + 1, 300);
        end

        // Adder input held busy for five cycles while ISSUE presents the operands.
        adderLat = 2; extraLatA = 5; addBusyHold = 5; pre = addXferCount;
        applyStimulus(0, 32'h40490FDB, 32'hC0490FDB, fakeAdd(32'h40490FDB, 32'hC0490FDB));
        waitResults(resultsDone + 1, 300);
        checkOutput("addXferOnce", addXferCount - pre, 1);
        checkOutput("addBusyConsumed", addBusyHold, 0);
        extraLatA = 0;

        // B stalls its result for three cycles while A waits with stb high.
        extraLatB = 3; bResHold = 3;
        applyStimulus(1, 32'hDEADBEEF, 32'h01234567, fakeAdd(32'hDEADBEEF, 32'h01234567));
        applyStimulus(0, 32'hCAFEF00D, 32'h76543210, fakeAdd(32'hCAFEF00D, 32'h76543210));
        waitResults(resultsDone + 2, 300);
        checkOutput("bResBusyConsumed", bResHold, 0);
        extraLatB = 0;

        // Reset lands while the adder is computing; its late result must be ignored.
        adderLat = 6;
        applyStimulus(0, 32'h0BADF00D, 32'h00C0FFEE, fakeAdd(32'h0BADF00D, 32'h00C0FFEE));
        k = 0;
        while (cnt == 0 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        checkOutput("reachedWaitResult", cnt != 0, 1);
        rst = 1'b1;
        expA.delete(); expB.delete(); orderLog.delete();
        #1;
        checkOutput("midRstResStb", {a_res_stb, b_res_stb}, 0);
        checkOutput("midRstAddOutBusy", add_out_busy, 1);
        checkOutput("midRstAddStb", add_stb, 0);
        checkOutput("midRstAddInA", add_in_a, 0);
        @(posedge clk);
        #1;
        checkOutput("midRstABusy", a_busy, 1);
        #1;
        rst = 1'b0;
        k = 0;
        while (!add_out_stb && k < 20) begin
            @(posedge clk);
            k++;
        end
        #2;
        checkOutput("lateOutStbRaised", add_out_stb, 1);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("lateIgnoredBusy", add_out_busy, 1);
        checkOutput("lateIgnoredRes", {a_res_stb, b_res_stb}, 0);
        clearReq++;
        repeat (2) @(posedge clk);
        #2;

        // Round robin: A wins the first tie after reset, waiting B beats A's re-request,
        // and a later tie after A was served goes to B.
        adderLat = 1;
        applyStimulus(0, 32'h00000011, 32'h00000022, fakeAdd(32'h00000011, 32'h00000022));
        applyStimulus(0, 32'h00000033, 32'h00000044, fakeAdd(32'h00000033, 32'h00000044));
        applyStimulus(1, 32'h00000055, 32'h00000066, fakeAdd(32'h00000055, 32'h00000066));
        waitResults(resultsDone + 3, 300);
        applyStimulus(0, 32'h00000077, 32'h00000088, fakeAdd(32'h00000077, 32'h00000088));
        applyStimulus(1, 32'h00000099, 32'h000000AA, fakeAdd(32'h00000099, 32'h000000AA));
        waitResults(resultsDone + 2, 300);
        checkOutput("orderLen", orderLog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < orderLog.size()) checkOutput($sformatf("order%0d", i), orderLog[i], expOrder[i]);
        end
`ifdef FPU_ARB_GRANT_CNT_EN
        checkOutput("aGrantCnt", a_grant_cnt, 3);
        checkOutput("bGrantCnt", b_grant_cnt, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=%0d required=%0d", cyc, 0);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
